multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle control unit for the 16-bit datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the select lines of the ALU operand muxes (ALUSrcA, 2-bit ALUSrcB), ALUOp, PC/IR/register/memory enables, and a retired-instruction counter.
- Sits between the instruction register's opcode field and the datapath mux/enable inputs; stalls on a memory-ready handshake.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter.
- HALT_OP, 4'hF, opcode that halts the machine.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Opcode  input  4  IR[15:12]; stable from DECODE until instruction end.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=register B, 01=constant 1, 10=sign-extended imm, 11=imm<<1.
- ALUOp  output  2  00=add, 01=sub, 10=use funct field.
- IorD  output  1  0=PC address, 1=ALUOut address.
- MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, PCWrite, PCWriteCond  output  1 each  datapath enables.
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target.
- Halted  output  1  high in HALT.
- IllegalOp  output  1  one-cycle pulse on undefined opcode.
- InstrCount  output  CNT_WIDTH  instructions retired since reset.

Behaviour:
- Reset: async on Reset_n=0. State=RST; every output 0; InstrCount=0. RST→FETCH on the first clock after release. Reset mid-instruction aborts with no further enables.
- Outputs are Moore (decoded from state) except IRWrite/PCWrite in FETCH, which are gated by MemReady. Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - If MemReady=0: hold in FETCH.
  - If MemReady=1: IRWrite=1, PCWrite=1, →DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 0 →EXEC_R
  - 1 →EXEC_I
  - 2 or 3 →MEM_ADDR
  - 4 →BRANCH
  - 5 →JUMP
  - HALT_OP →HALT
  - other →TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; →ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; →ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=(Opcode==0); →FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Opcode 2 →MEM_RD, Opcode 3 →MEM_WR.
- MEM_RD: MemRead=1, IorD=1; hold until MemReady=1, then →MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; →FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until MemReady=1, then →FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; →FETCH. The datapath ANDs PCWriteCond with Zero; the FSM does not use Zero.
- JUMP: PCWrite=1, PCSource=10; →FETCH.
- TRAP: IllegalOp=1 for exactly one cycle; →FETCH; not counted as retired.
- HALT: Halted=1, all enables 0; stays until reset.
- InstrCount: increments by 1 on the final cycle of each instruction:
  - ALU_WB, MEM_WB, BRANCH, JUMP
  - MEM_WR when MemReady=1
  - entry to HALT
- InstrCount wraps from all-ones to 0 silently.
- Latency with MemReady tied high: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
- Each wait cycle on MemReady adds one cycle. No outputs change during a wait, except IRWrite/PCWrite staying low.
- The state register uses one-hot or binary encoding (designer's choice); unreachable encodings →RST-equivalent outputs and →FETCH.

Test Plan:
- Reset held, then released with MemReady=1, Opcode=0 → all outputs 0 during reset; FETCH with IRWrite=PCWrite=1 next cycle; RegWrite=1, RegDst=1 in cycle 4; InstrCount=1.
- lw (Opcode=2) with MemReady low for 3 cycles in MEM_RD → MemRead=IorD=1 held 4 cycles, then MEM_WB with MemtoReg=1; total 8 cycles.
- beq (Opcode=4) → BRANCH shows ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; back in FETCH 3 cycles after start.
- Opcode=4'h9 → IllegalOp high exactly one cycle, then FETCH; InstrCount unchanged.
- Opcode=HALT_OP → Halted=1 indefinitely with enables 0. Then assert Reset_n=0 asynchronously mid-cycle → outputs 0 immediately; InstrCount=0.
- Preload InstrCount to all-ones via 2^16−1 j instructions (or a forced value) → one more j yields InstrCount=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Latency with MemReady high: R/addi 4, lw 5, sw 4, beq 3, j 3 cycles; HALT is terminal until reset.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while MemReady=0, outputs frozen (FETCH IRWrite/PCWrite low).
module multicycle_control_fsm #(
  parameter int          CNT_WIDTH = 16,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic [3:0]           Opcode,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 Halted,
  output logic                 IllegalOp,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  logic [3:0] state, state_nxt;
  logic       retire;

  // The datapath gates PCWriteCond with Zero itself; the flag is not needed here.
  logic unused_zero;
  assign unused_zero = Zero;

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:      state_nxt = S_FETCH;
      S_FETCH:    if (MemReady) state_nxt = S_DECODE;
      S_DECODE: begin
        if (Opcode == HALT_OP)   state_nxt = S_HALT;
        else begin
          case (Opcode)
            4'd0:        state_nxt = S_EXEC_R;
            4'd1:        state_nxt = S_EXEC_I;
            4'd2, 4'd3:  state_nxt = S_MEM_ADDR;
            4'd4:        state_nxt = S_BRANCH;
            4'd5:        state_nxt = S_JUMP;
            default:     state_nxt = S_TRAP;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = Opcode[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (MemReady) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (MemReady) state_nxt = S_FETCH;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_TRAP: state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Retirement is counted on each instruction's last cycle; HALT counts on entry.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR: retire = MemReady;
      S_DECODE: retire = (Opcode == HALT_OP);
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_RST;
      InstrCount <= '0;
    end else begin
      state <= state_nxt;
      if (retire) InstrCount <= InstrCount + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    Halted      = 1'b0;
    IllegalOp   = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = (Opcode == 4'd0);
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_TRAP:  IllegalOp = 1'b1;
      S_HALT:  Halted    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; counter narrowed to 8 bits so the wrap case stays short.
module tb_multicycle_control_fsm;

  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic [3:0]    Opcode;
  logic          Zero;
  logic          MemReady;
  logic          ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst;
  logic          PCWrite, PCWriteCond, Halted, IllegalOp;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [CW-1:0] InstrCount;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multicycle_control_fsm #(.CNT_WIDTH(CW), .HALT_OP(4'hF)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .Halted(Halted), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  // {ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg,
  //  RegDst, PCWrite, PCWriteCond, PCSource, Halted, IllegalOp}
  logic [17:0] ctl;
  assign ctl = {ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                MemtoReg, RegDst, PCWrite, PCWriteCond, PCSource, Halted, IllegalOp};

  localparam logic [17:0] C_IDLE   = 18'b0;
  localparam logic [17:0] C_FETCH  = {1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_FWAIT  = {1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_DECODE = {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_EXEC_R = {1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_EXEC_I = {1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_WB_R   = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_WB_I   = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_MEM_RD = {1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_MEM_WB = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_MEM_WR = {1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_BRANCH = {1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
  localparam logic [17:0] C_JUMP   = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] C_TRAP   = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [17:0] C_HALT   = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [17:0] exp);
    chk(tag, 32'(ctl), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk(tag, 32'(InstrCount), 32'(exp));
  endtask

  initial begin
    Reset_n  = 1'b0;
    Opcode   = 4'd0;
    Zero     = 1'b0;
    MemReady = 1'b1;
    #1;
    chk_ctl("reset_ctl", C_IDLE);
    chk_cnt("reset_cnt", 0);
    step(); step();
    chk_ctl("reset_held_ctl", C_IDLE);
    Reset_n = 1'b1;

    // add (R-type): 4 cycles
    step(); chk_ctl("r_fetch", C_FETCH);
    step(); chk_ctl("r_decode", C_DECODE);
    step(); chk_ctl("r_exec", C_EXEC_R);
    step(); chk_ctl("r_wb", C_WB_R); chk_cnt("r_cnt_before", 0);
    step(); chk_cnt("r_cnt", 1);

    // fetch stall: IRWrite/PCWrite low, state held
    MemReady = 1'b0; #1;
    chk_ctl("fetch_wait0", C_FWAIT);
    step(); chk_ctl("fetch_wait1", C_FWAIT);
    MemReady = 1'b1; #1;
    chk_ctl("fetch_ready", C_FETCH);

    // lw with three wait cycles in MEM_RD: 8 cycles total
    Opcode = 4'd2;
    step(); chk_ctl("lw_decode", C_DECODE);
    step(); chk_ctl("lw_addr", C_EXEC_I);
    step(); MemReady = 1'b0; #1; chk_ctl("lw_rd0", C_MEM_RD);
    step(); chk_ctl("lw_rd1", C_MEM_RD);
    step(); chk_ctl("lw_rd2", C_MEM_RD);
    step(); MemReady = 1'b1; #1; chk_ctl("lw_rd3", C_MEM_RD);
    step(); chk_ctl("lw_wb", C_MEM_WB); chk_cnt("lw_cnt_before", 1);
    step(); chk_ctl("lw_done_fetch", C_FETCH); chk_cnt("lw_cnt", 2);

    // sw: 4 cycles, retires in MEM_WR
    Opcode = 4'd3;
    step(); chk_ctl("sw_decode", C_DECODE);
    step(); chk_ctl("sw_addr", C_EXEC_I);
    step(); chk_ctl("sw_wr", C_MEM_WR);
    step(); chk_ctl("sw_done_fetch", C_FETCH); chk_cnt("sw_cnt", 3);

    // addi: RegDst stays 0
    Opcode = 4'd1;
    step(); step(); chk_ctl("addi_exec", C_EXEC_I);
    step(); chk_ctl("addi_wb", C_WB_I);
    step(); chk_cnt("addi_cnt", 4);

    // beq: back in FETCH 3 cycles after start, independent of Zero
    Opcode = 4'd4; Zero = 1'b1;
    step(); chk_ctl("beq_decode", C_DECODE);
    step(); chk_ctl("beq_branch", C_BRANCH);
    step(); chk_ctl("beq_fetch", C_FETCH); chk_cnt("beq_cnt", 5);
    Zero = 1'b0;

    // j
    Opcode = 4'd5;
    step(); step(); chk_ctl("j_jump", C_JUMP);
    step(); chk_ctl("j_fetch", C_FETCH); chk_cnt("j_cnt", 6);

    // undefined opcode: one-cycle IllegalOp, not retired
    Opcode = 4'h9;
    step(); step(); chk_ctl("trap", C_TRAP);
    step(); chk_ctl("trap_fetch", C_FETCH); chk_cnt("trap_cnt", 6);

    // counter wrap: 249 more jumps reach 255, the next one wraps to 0
    Opcode = 4'd5;
    for (int i = 0; i < 249; i++) begin
      step(); step(); step();
    end
    chk_cnt("cnt_allones", 255);
    step(); step(); step();
    chk_cnt("cnt_wrap", 0);

    // halt: counted once on entry, then holds
    Opcode = 4'hF;
    step(); chk_ctl("halt_decode", C_DECODE); chk_cnt("halt_cnt_before", 0);
    step(); chk_ctl("halt0", C_HALT); chk_cnt("halt_cnt", 1);
    for (int i = 0; i < 5; i++) step();
    chk_ctl("halt_hold", C_HALT); chk_cnt("halt_cnt_hold", 1);

    // asynchronous reset mid-cycle
    @(posedge CLK); #3;
    Reset_n = 1'b0; #1;
    chk_ctl("async_rst_ctl", C_IDLE);
    chk_cnt("async_rst_cnt", 0);
    step(); Reset_n = 1'b1;
    Opcode = 4'd0;
    step(); chk_ctl("post_rst_fetch", C_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
